de_exm_buffer: RTL and testbench
================================

// Module: de_exm_buffer
// PURPOSE
//  Decode->execute/memory pipeline register feeding exm_stage.
//  - Registers the decoded control bundle and operands, and inserts bubbles on load-use stall or branch flush.
//  - Sequences two-cycle stack ops (CALL/RET/RTI/INT), which move the 32-bit PC as two 16-bit words:
//    holds the instruction for a second EX cycle with o_hazard_state=1 and back-pressures decode meanwhile.
// PARAMETERS
//  DATA_W  16  operand/immediate width
//  PC_W    32  program counter width
//  REG_W   3   register index width
//  CTRL_W  24  packed control bundle width (field map in pipeline_defs.vh)
// PORTS
//  i_clk            in   1       clock, all state on rising edge
//  i_reset          in   1       asynchronous, active-low reset
//  i_valid          in   1       decode presents an instruction this cycle
//  i_ctrl           in   CTRL_W  packed decoded control (alu_function..branch_flags)
//  i_multi_cycle    in   1       instruction needs two EX cycles (PC push/pop)
//  i_data1,i_data2  in   DATA_W  register-file operands
//  i_immediate      in   DATA_W  immediate word
//  i_sh_amount      in   DATA_W  shift amount, zero-extended
//  i_rd,i_rs        in   REG_W   source register indices (for forwarding unit)
//  i_write_addr     in   REG_W   destination register
//  i_pc             in   PC_W    PC to push for CALL/INT
//  i_stall          in   1       load-use hazard from hazard unit
//  i_flush          in   1       taken branch (exm o_branch_decision)
//  o_ctrl           out  CTRL_W  registered control bundle to exm_stage
//  o_data1,o_data2,o_immediate,o_sh_amount  out DATA_W  registered operands
//  o_rd,o_rs,o_write_addr                   out REG_W   registered indices
//  o_pc             out  PC_W    registered PC
//  o_hazard_state   out  1       1 during second EX cycle of a multi-cycle op
//  o_stall_upstream out  1       decode/fetch must hold its current instruction
// BEHAVIOUR
//  - Reset (i_reset=0, async): every output register 0, phase=0, held_multi=0. The bundle is a NOP.
//  - Latency: one cycle, decode -> exm.
//  - State: phase bit (0=first/only EX cycle, 1=second cycle) and held_multi (registered i_multi_cycle).
//  - o_hazard_state = phase. o_stall_upstream = ~phase & held_multi (combinational from registers).
//  - Next-state priority per rising edge:
//    1. i_flush & ~o_stall_upstream: load bubble, phase<=0, held_multi<=0.
//    2. o_stall_upstream: keep all operand/control registers, phase<=1.
//    3. phase==1: final half done; load from decode as in rules 4/5, phase<=0.
//    4. i_stall | ~i_valid: load bubble, phase<=0.
//    5. otherwise: load all inputs, held_multi<=i_multi_cycle, phase<=0.
//  - Bubble: o_ctrl<=0 (no write_back, mem, stack or branch); data/index/pc registers also <=0.
//  - i_flush is ignored while o_stall_upstream=1, so a multi-cycle op cannot kill its own second half.
//  - Flush in phase 1 terminates the op normally: the bubble is loaded, phase returns to 0.
//  - i_stall during phase 1 yields a bubble after the op. i_stall during the first half is ignored (rule 2 wins).
//  - Flush beats stall whenever both are asserted.
//  - No arithmetic: pure registers. Widths pass through unchanged.
//  - Reset mid-op (either phase) returns immediately to NOP, phase 0. Decode stall released.
// STRUCTURE
//  - pipeline_defs.vh holds the CTRL_* field offsets/widths (ALU_FN, WB_SEL, BR_SEL, MOV, ... BRANCH_FLAGS),
//    CTRL_W and the NOP bundle constant. exm_stage and decode share it.
//  - One sub-module: pipe_reg #(W), an async-active-low-reset register with load enable, instantiated per field group.
//  - Phase/held_multi logic inline in this module.
// TESTING
//  - Reset: assert i_reset=0 mid-stream -> all outputs 0, o_hazard_state=0, o_stall_upstream=0.
//  - ALU op: i_valid=1, data1=16'h0005, data2=16'h0003, ctrl=ADD
//    -> next cycle o_data1=5, o_data2=3, o_ctrl=ADD, o_hazard_state=0.
//  - CALL: i_multi_cycle=1, push_pc=1, i_pc=32'h0000_0123 -> cycle1 o_stall_upstream=1, hz=0;
//    cycle2 same bundle, hz=1, stall=0; cycle3 next instr loaded.
//  - Load-use: i_stall=1 with valid ADD -> o_ctrl=NOP next cycle. Instr loaded on the following cycle once stall drops.
//  - Flush: i_flush=1 with valid instr -> o_ctrl=NOP. i_flush=1 during CALL first half -> ignored, second half still issues (hz=1).
//  - Flush+stall together -> NOP, phase 0. Stall during RET phase 1 -> RET completes, then NOP.

Source files
------------

// File: rtl/de_exm_buffer_pkg.sv
// Shared decode/execute definitions: control-bundle field map, NOP bundle and default widths.
// Decode, this buffer and exm_stage all interpret the packed control word through ctrl_t.
package de_exm_buffer_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_PC_W   = 32;
    localparam int DEF_REG_W  = 3;
    localparam int DEF_CTRL_W = 24;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_NOT  = 4'd6,
        ALU_SHL  = 4'd7,
        ALU_SHR  = 4'd8,
        ALU_INC  = 4'd9,
        ALU_DEC  = 4'd10,
        ALU_PASS = 4'd11
    } alu_fn_e;

    // Field order MSB..LSB; alu_fn occupies bits [3:0], branch_flags bits [23:20].
    typedef struct packed {
        logic [3:0] branch_flags;
        logic       rti;
        logic       int_op;
        logic       use_shamt;
        logic       use_imm;
        logic       stack_pop;
        logic       stack_push;
        logic       pop_pc;
        logic       push_pc;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mov;
        logic [1:0] br_sel;
        logic [1:0] wb_sel;
        alu_fn_e    alu_fn;
    } ctrl_t;

    localparam int CTRL_ALU_FN_LSB       = 0;
    localparam int CTRL_WB_SEL_LSB       = 4;
    localparam int CTRL_BR_SEL_LSB       = 6;
    localparam int CTRL_MOV_BIT          = 8;
    localparam int CTRL_PUSH_PC_BIT      = 12;
    localparam int CTRL_POP_PC_BIT       = 13;
    localparam int CTRL_BRANCH_FLAGS_LSB = 20;

    localparam logic [DEF_CTRL_W-1:0] CTRL_NOP = '0;

    function automatic logic [DEF_CTRL_W-1:0] ctrl_of(alu_fn_e fn, logic push_pc, logic pop_pc);
        ctrl_t c;
        c            = '0;
        c.alu_fn     = fn;
        c.reg_write  = ~(push_pc | pop_pc);
        c.push_pc    = push_pc;
        c.pop_pc     = pop_pc;
        c.stack_push = push_pc;
        c.stack_pop  = pop_pc;
        return c;
    endfunction

endpackage

// File: rtl/de_exm_buffer_pipe_reg.sv
// Field-group pipeline register: async active-low clear, loads d_i when en_i is high.
module pipe_reg #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/de_exm_buffer.sv
// Decode -> execute/memory pipeline register with bubble insertion and the
// two-cycle sequencing used by PC push/pop stack operations.
module de_exm_buffer
    import de_exm_buffer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PC_W   = DEF_PC_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_multi_cycle,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  logic [DATA_W-1:0] i_immediate,
    input  logic [DATA_W-1:0] i_sh_amount,
    input  logic [REG_W-1:0]  i_rd,
    input  logic [REG_W-1:0]  i_rs,
    input  logic [REG_W-1:0]  i_write_addr,
    input  logic [PC_W-1:0]   i_pc,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data1,
    output logic [DATA_W-1:0] o_data2,
    output logic [DATA_W-1:0] o_immediate,
    output logic [DATA_W-1:0] o_sh_amount,
    output logic [REG_W-1:0]  o_rd,
    output logic [REG_W-1:0]  o_rs,
    output logic [REG_W-1:0]  o_write_addr,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_hazard_state,
    output logic              o_stall_upstream
);

    localparam int OPND_W = 4 * DATA_W;
    localparam int IDX_W  = 3 * REG_W;

    logic phase_q, phase_d;
    logic held_multi_q, held_multi_d;
    logic stall_up;
    logic load_en;
    logic bubble;

    logic [CTRL_W-1:0] ctrl_d;
    logic [OPND_W-1:0] opnd_d, opnd_q;
    logic [IDX_W-1:0]  idx_d, idx_q;
    logic [PC_W-1:0]   pc_d;

    // First half of a multi-cycle op is in EX: decode must hold, and flush is ignored.
    assign stall_up         = ~phase_q & held_multi_q;
    assign o_stall_upstream = stall_up;
    assign o_hazard_state   = phase_q;

    always_comb begin
        phase_d      = 1'b0;
        held_multi_d = held_multi_q;
        load_en      = 1'b1;
        bubble       = 1'b0;
        if (i_flush && !stall_up) begin
            bubble       = 1'b1;
            held_multi_d = 1'b0;
        end else if (stall_up) begin
            load_en      = 1'b0;
            phase_d      = 1'b1;
        end else if (i_stall || !i_valid) begin
            bubble       = 1'b1;
            held_multi_d = 1'b0;
        end else begin
            held_multi_d = i_multi_cycle;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            phase_q      <= 1'b0;
            held_multi_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            held_multi_q <= held_multi_d;
        end
    end

    // A bubble clears every field so exm_stage sees a clean NOP with zero operands.
    always_comb begin
        ctrl_d = i_ctrl;
        opnd_d = {i_data1, i_data2, i_immediate, i_sh_amount};
        idx_d  = {i_rd, i_rs, i_write_addr};
        pc_d   = i_pc;
        if (bubble) begin
            ctrl_d = CTRL_W'(CTRL_NOP);
            opnd_d = '0;
            idx_d  = '0;
            pc_d   = '0;
        end
    end

    pipe_reg #(.W(CTRL_W)) u_ctrl_reg (
        .clk_i  (i_clk),
        .rst_ni (i_reset),
        .en_i   (load_en),
        .d_i    (ctrl_d),
        .q_o    (o_ctrl)
    );

    pipe_reg #(.W(OPND_W)) u_opnd_reg (
        .clk_i  (i_clk),
        .rst_ni (i_reset),
        .en_i   (load_en),
        .d_i    (opnd_d),
        .q_o    (opnd_q)
    );

    pipe_reg #(.W(IDX_W)) u_idx_reg (
        .clk_i  (i_clk),
        .rst_ni (i_reset),
        .en_i   (load_en),
        .d_i    (idx_d),
        .q_o    (idx_q)
    );

    pipe_reg #(.W(PC_W)) u_pc_reg (
        .clk_i  (i_clk),
        .rst_ni (i_reset),
        .en_i   (load_en),
        .d_i    (pc_d),
        .q_o    (o_pc)
    );

    assign {o_data1, o_data2, o_immediate, o_sh_amount} = opnd_q;
    assign {o_rd, o_rs, o_write_addr}                   = idx_q;

endmodule

// File: tb/tb_de_exm_buffer.sv
// Scoreboard bench for de_exm_buffer: directed scenarios followed by randomized traffic.
module tb_de_exm_buffer;
    import de_exm_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [23:0] i_ctrl;
    logic        i_multi_cycle;
    logic [15:0] i_data1, i_data2, i_immediate, i_sh_amount;
    logic [2:0]  i_rd, i_rs, i_write_addr;
    logic [31:0] i_pc;
    logic        i_stall, i_flush;
    logic [23:0] o_ctrl;
    logic [15:0] o_data1, o_data2, o_immediate, o_sh_amount;
    logic [2:0]  o_rd, o_rs, o_write_addr;
    logic [31:0] o_pc;
    logic        o_hazard_state, o_stall_upstream;

    always #5 clk = ~clk;

    de_exm_buffer dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_valid          (i_valid),
        .i_ctrl           (i_ctrl),
        .i_multi_cycle    (i_multi_cycle),
        .i_data1          (i_data1),
        .i_data2          (i_data2),
        .i_immediate      (i_immediate),
        .i_sh_amount      (i_sh_amount),
        .i_rd             (i_rd),
        .i_rs             (i_rs),
        .i_write_addr     (i_write_addr),
        .i_pc             (i_pc),
        .i_stall          (i_stall),
        .i_flush          (i_flush),
        .o_ctrl           (o_ctrl),
        .o_data1          (o_data1),
        .o_data2          (o_data2),
        .o_immediate      (o_immediate),
        .o_sh_amount      (o_sh_amount),
        .o_rd             (o_rd),
        .o_rs             (o_rs),
        .o_write_addr     (o_write_addr),
        .o_pc             (o_pc),
        .o_hazard_state   (o_hazard_state),
        .o_stall_upstream (o_stall_upstream)
    );

    typedef struct packed {
        logic [23:0] ctrl;
        logic [15:0] d1, d2, imm, sh;
        logic [2:0]  rd, rs, wa;
        logic [31:0] pc;
        logic        hz;
        logic        su;
    } snap_t;

    snap_t q[$];
    snap_t m;            // what the EX slot holds after the most recent edge
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            snap_t e;
            e = q.pop_front();
            chk("ctrl",      32'(o_ctrl),           32'(e.ctrl));
            chk("data1",     32'(o_data1),          32'(e.d1));
            chk("data2",     32'(o_data2),          32'(e.d2));
            chk("immediate", 32'(o_immediate),      32'(e.imm));
            chk("sh_amount", 32'(o_sh_amount),      32'(e.sh));
            chk("rd",        32'(o_rd),             32'(e.rd));
            chk("rs",        32'(o_rs),             32'(e.rs));
            chk("write_addr",32'(o_write_addr),     32'(e.wa));
            chk("pc",        o_pc,                  e.pc);
            chk("hazard",    32'(o_hazard_state),   32'(e.hz));
            chk("stall_up",  32'(o_stall_upstream), 32'(e.su));
        end
    end

    task automatic set_in(input bit v, input logic [23:0] c, input bit mc,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] pc, input bit st, input bit fl);
        i_valid       = v;
        i_ctrl        = c;
        i_multi_cycle = mc;
        i_data1       = a;
        i_data2       = b;
        i_immediate   = 16'($urandom);
        i_sh_amount   = 16'($urandom_range(0, 15));
        i_rd          = 3'($urandom);
        i_rs          = 3'($urandom);
        i_write_addr  = 3'($urandom);
        i_pc          = pc;
        i_stall       = st;
        i_flush       = fl;
    endtask

    // Reference behaviour: a stack op occupies EX for two cycles and decode waits
    // during the first; otherwise flush, then stall/invalid, produce a NOP slot.
    task automatic step();
        snap_t n;
        n = m;
        if (m.su) begin
            n.hz = 1'b1;
            n.su = 1'b0;
        end else if (i_flush || i_stall || !i_valid) begin
            n = '0;
        end else begin
            n.ctrl = i_ctrl;
            n.d1 = i_data1;   n.d2 = i_data2;
            n.imm = i_immediate; n.sh = i_sh_amount;
            n.rd = i_rd;      n.rs = i_rs;      n.wa = i_write_addr;
            n.pc = i_pc;
            n.hz = 1'b0;
            n.su = i_multi_cycle;
        end
        @(posedge clk);
        #1;
        m = n;
        q.push_back(m);
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic reset_mid();
        @(negedge clk);
        #1;
        i_reset = 1'b0;
        #1;
        chk("async_rst_ctrl",  32'(o_ctrl),           32'h0);
        chk("async_rst_pc",    o_pc,                  32'h0);
        chk("async_rst_hz",    32'(o_hazard_state),   32'h0);
        chk("async_rst_stall", 32'(o_stall_upstream), 32'h0);
        m = '0;
        @(posedge clk);
        #1;
        q.push_back(m);
        #1;
        i_reset = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [23:0] add_c, call_c, ret_c;

    initial begin
        add_c  = ctrl_of(ALU_ADD, 1'b0, 1'b0);
        call_c = ctrl_of(ALU_PASS, 1'b1, 1'b0);
        ret_c  = ctrl_of(ALU_PASS, 1'b0, 1'b1);
        m = '0;
        i_reset = 1'b0;
        set_in(0, 24'h0, 0, 16'h0, 16'h0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        q.push_back(m);
        #1;
        i_reset = 1'b1;

        // ALU op
        set_in(1, add_c, 0, 16'h0005, 16'h0003, 32'h10, 0, 0); step();
        // CALL: held one extra cycle, next instruction waits
        set_in(1, call_c, 1, 16'h1111, 16'h2222, 32'h0000_0123, 0, 0); step();
        set_in(1, add_c, 0, 16'h0007, 16'h0009, 32'h11, 0, 0); step();
        step();
        // load-use stall then release
        set_in(1, add_c, 0, 16'h00AA, 16'h00BB, 32'h12, 1, 0); step();
        i_stall = 1'b0; step();
        // flush with valid instruction
        set_in(1, add_c, 0, 16'h0C0C, 16'h0D0D, 32'h13, 0, 1); step();
        // flush during CALL first half ignored, flush in second half terminates normally
        set_in(1, call_c, 1, 16'h3333, 16'h4444, 32'h0000_0456, 0, 0); step();
        i_flush = 1'b1; step();
        step();
        // flush and stall together
        set_in(1, add_c, 0, 16'h0101, 16'h0202, 32'h14, 1, 1); step();
        // stall during RET second half -> RET completes, then bubble
        set_in(1, ret_c, 1, 16'h5555, 16'h6666, 32'h15, 0, 0); step();
        i_stall = 1'b1; step();
        step();
        // reset while a CALL is in its first half
        set_in(1, call_c, 1, 16'h7777, 16'h8888, 32'hCAFE_0001, 0, 0); step();
        reset_mid();
        set_in(1, add_c, 0, 16'h0001, 16'h0002, 32'h16, 0, 0); step();

        for (int i = 0; i < 2000; i++) begin
            set_in($urandom_range(0, 9) < 8, 24'($urandom), $urandom_range(0, 3) == 0,
                   16'($urandom), 16'($urandom), $urandom,
                   $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
            step();
            if (i == 1000) reset_mid();
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
